// File: rtl/instr_fetch_ir.sv
// Instruction fetch and IR stage: owns the PC, runs the memory read handshake
// with wait-state/timeout handling and latches the returned word into the IR.
module instr_fetch_ir #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [31:0] pc_load_val,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic [31:0] pc,
    output logic        busy,
    output logic        fetch_done,
    output logic        fetch_err
);

    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [31:0]       pc_d, instr_d, mem_addr_d;
    logic              mem_req_d, busy_d, fetch_done_d, fetch_err_d;

    // State and registered outputs; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pc         <= RESET_PC;
            instr      <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            pc         <= pc_d;
            instr      <= instr_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            busy       <= busy_d;
            fetch_done <= fetch_done_d;
            fetch_err  <= fetch_err_d;
        end
    end

    // Next-state and next-output logic; fetch_done is a single-cycle pulse.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        pc_d         = pc;
        instr_d      = instr;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        busy_d       = busy;
        fetch_done_d = 1'b0;
        fetch_err_d  = fetch_err;

        case (state)
            IDLE: begin
                if (pc_load) begin
                    pc_d = pc_load_val;
                end else if (fetch_start) begin
                    if (pc[1:0] != 2'b00) begin
                        fetch_err_d = 1'b1;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_addr_d  = pc;
                        busy_d      = 1'b1;
                        fetch_err_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                // Ready is checked before the timeout so a late ready still wins.
                if (mem_ready) begin
                    instr_d      = mem_rdata;
                    pc_d         = pc + 32'd4;
                    mem_req_d    = 1'b0;
                    busy_d       = 1'b0;
                    fetch_done_d = 1'b1;
                    state_d      = IDLE;
                end else if (cnt == CNT_LAST) begin
                    mem_req_d   = 1'b0;
                    busy_d      = 1'b0;
                    fetch_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];
    assign jaddr  = instr[25:0];

endmodule

// File: tb/tb_instr_fetch_ir.sv
// Bench for instr_fetch_ir: fetch vector table with a completion scoreboard,
// plus hand sequences for reset and reset-during-wait.
module tb_instr_fetch_ir;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_start, pc_load, mem_ready;
    logic [31:0] pc_load_val, mem_rdata;
    logic        mem_req, busy, fetch_done, fetch_err;
    logic [31:0] mem_addr, instr, pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] jaddr;

    instr_fetch_ir #(.RESET_PC(32'h0), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instr(instr),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .jaddr(jaddr), .pc(pc), .busy(busy),
        .fetch_done(fetch_done), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [31:0] ld_val;
        logic [31:0] rdata;
        int          waits;      // ready after this many wait cycles; >= TIMEOUT never
        logic        exp_req;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] model_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every fetch_done must match the oldest expected completion.
    always @(negedge clk) begin
        if (fetch_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_done: got fetch_done=1, expected 0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_instr",  instr, e.instr);
                chk("done_pc",     pc, e.pc);
                chk("done_opcode", 32'(opcode), 32'(e.instr[31:26]));
                chk("done_rs",     32'(rs), 32'(e.instr[25:21]));
                chk("done_rt",     32'(rt), 32'(e.instr[20:16]));
                chk("done_rd",     32'(rd), 32'(e.instr[15:11]));
                chk("done_shamt",  32'(shamt), 32'(e.instr[10:6]));
                chk("done_funct",  32'(funct), 32'(e.instr[5:0]));
                chk("done_imm16",  32'(imm16), 32'(e.instr[15:0]));
                chk("done_jaddr",  32'(jaddr), 32'(e.instr[25:0]));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        logic [31:0] exp_addr;
        int          n;
        if (v.ld) begin
            @(negedge clk);
            pc_load = 1'b1; pc_load_val = v.ld_val; fetch_start = 1'b1;
            @(negedge clk);
            pc_load = 1'b0; fetch_start = 1'b0;
            chk("ld_no_req", 32'(mem_req), 32'd0);
            chk("ld_pc", pc, v.ld_val);
            model_pc = v.ld_val;
        end
        exp_addr = model_pc;
        @(negedge clk);
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        if (!v.exp_req) begin
            chk("misalign_no_req", 32'(mem_req), 32'd0);
            chk("misalign_err", 32'(fetch_err), 32'd1);
            @(negedge clk);
            chk("misalign_req_stays0", 32'(mem_req), 32'd0);
        end else begin
            if (v.waits < int'(TIMEOUT)) sb.push_back('{instr: v.exp_instr, pc: v.exp_pc});
            n = (v.waits < int'(TIMEOUT)) ? v.waits + 1 : int'(TIMEOUT);
            for (int i = 0; i < n; i++) begin
                chk("wait_req", 32'(mem_req), 32'd1);
                chk("wait_addr", mem_addr, exp_addr);
                chk("wait_busy", 32'(busy), 32'd1);
                mem_rdata = v.rdata;
                mem_ready = (i == v.waits);
                @(negedge clk);
            end
            mem_ready = 1'b0;
            chk("end_req", 32'(mem_req), 32'd0);
            chk("end_busy", 32'(busy), 32'd0);
        end
        chk("final_pc", pc, v.exp_pc);
        chk("final_instr", instr, v.exp_instr);
        chk("final_err", 32'(fetch_err), 32'(v.exp_err));
        model_pc = v.exp_pc;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 32'h0,         32'h8C22FFFC, 0,  1'b1, 32'h4,  32'h8C22FFFC, 1'b0};
        vecs[1] = '{1'b0, 32'h0,         32'h00A63020, 3,  1'b1, 32'h8,  32'h00A63020, 1'b0};
        vecs[2] = '{1'b0, 32'h0,         32'h12345678, 16, 1'b1, 32'h8,  32'h00A63020, 1'b1};
        vecs[3] = '{1'b0, 32'h0,         32'hAC430008, 15, 1'b1, 32'hC,  32'hAC430008, 1'b0};
        vecs[4] = '{1'b1, 32'h40,        32'h08000010, 0,  1'b1, 32'h44, 32'h08000010, 1'b0};
        vecs[5] = '{1'b1, 32'h42,        32'hDEADBEEF, 0,  1'b0, 32'h42, 32'h08000010, 1'b1};
        vecs[6] = '{1'b1, 32'hFFFFFFFC,  32'h3C01ABCD, 1,  1'b1, 32'h0,  32'h3C01ABCD, 1'b0};

        rst_n = 1'b0; fetch_start = 1'b0; pc_load = 1'b0; pc_load_val = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(fetch_done), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        rst_n = 1'b1;
        model_pc = 32'h0;

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Reset while waiting: request drops, PC/IR return to reset values, late ready ignored.
        @(negedge clk);
        pc_load = 1'b1; pc_load_val = 32'h80;
        @(negedge clk);
        pc_load = 1'b0; fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        chk("mid_req", 32'(mem_req), 32'd1);
        chk("mid_addr", mem_addr, 32'h80);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        mem_rdata = 32'hCAFEF00D; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        mem_ready = 1'b0;
        chk("late_ready_instr", instr, 32'h0);
        chk("late_ready_pc", pc, 32'h0);
        chk("late_ready_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_ir.md
Name: instr_fetch_ir

Overview:
Instruction fetch and instruction-register stage of the multicycle CPU, directly upstream of the sign extender. It is started by the control FSM. It owns the PC, runs a memory read handshake with wait-state and timeout support, and latches the returned word into the IR. It exposes the decoded fields; imm16 drives the sign extender input.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
TIMEOUT_CYC, 16, max cycles mem_req stays high awaiting mem_ready (range 1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
fetch_start  in  1  one-cycle fetch request from control FSM
pc_load  in  1  write pc_load_val into PC (branch/jump)
pc_load_val  in  32  new PC value
mem_req  out  1  memory read request
mem_addr  out  32  read address, stable while mem_req=1
mem_rdata  in  32  read data, valid when mem_ready=1
mem_ready  in  1  read-complete strobe, sampled only while mem_req=1
instr  out  32  instruction register
opcode  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
shamt  out  5  instr[10:6]
funct  out  6  instr[5:0]
imm16  out  16  instr[15:0], to sign extender
jaddr  out  26  instr[25:0]
pc  out  32  program counter
busy  out  1  high while in WAIT
fetch_done  out  1  one-cycle pulse: new instr and pc valid
fetch_err  out  1  sticky error: timeout or misaligned PC

Behaviour:
- One clock, reset is synchronous and active-low: all state updates on the rising edge of clk; rst_n=0 at an edge takes priority over everything else.
- Reset values: pc=RESET_PC; instr=0 (all fields 0); mem_req=0; mem_addr=0; busy=0; fetch_done=0; fetch_err=0; state=IDLE; wait counter=0.
- Field outputs are combinational slices of the instr register. There is no other logic on the fields.
- States: IDLE, WAIT.
- IDLE, pc_load=1: pc<=pc_load_val. fetch_start in the same cycle is ignored, so pc_load has priority.
- IDLE, fetch_start=1, pc_load=0, pc[1:0]!=0: no request is issued. fetch_err<=1 and the FSM stays in IDLE.
- IDLE, fetch_start=1, pc_load=0, pc aligned: mem_req<=1, mem_addr<=pc, busy<=1, fetch_err<=0, counter<=0, go to WAIT.
- WAIT, mem_ready=1: instr<=mem_rdata, pc<=pc+4 (wraps modulo 2^32), mem_req<=0, busy<=0, fetch_done<=1, go to IDLE.
- WAIT, mem_ready=0, counter==TIMEOUT_CYC-1: abort. mem_req<=0, busy<=0, fetch_err<=1, go to IDLE. instr and pc are unchanged and no fetch_done is issued.
- WAIT, mem_ready=0, otherwise: counter increments. mem_req and mem_addr hold.
- mem_ready on the final allowed cycle counts as success: ready beats timeout.
- fetch_start and pc_load are ignored while in WAIT.
- mem_ready is ignored while mem_req=0.
- fetch_done is high for exactly one cycle and defaults to 0 on every other cycle.
- Latency: fetch_start sampled at edge T gives mem_req=1 during cycle T+1. With zero wait states (mem_ready=1 in cycle T+1), instr, pc and fetch_done update at edge T+2. Each wait state adds one cycle.
- mem_req stays high for at most TIMEOUT_CYC cycles.
- fetch_err stays set until the next accepted aligned fetch_start or reset.
- Reset during WAIT: mem_req=0 from the next cycle. Any later mem_ready is ignored.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges -> pc=0, instr=0, mem_req=0, busy=0, fetch_done=0, fetch_err=0.
2. Zero-wait fetch: fetch_start at T; mem_ready=1 with mem_rdata=32'h8C22FFFC in cycle T+1 -> mem_addr=0 during T+1. At T+2: opcode=6'h23, rs=1, rt=2, imm16=16'hFFFC, pc=4, fetch_done high for one cycle.
3. Wait states: mem_ready delayed 3 cycles -> mem_req high for 4 cycles with mem_addr constant; fetch_done at T+5; pc advances by 4 exactly once.
4. Timeout, TIMEOUT_CYC=16, mem_ready never asserted -> mem_req high for exactly 16 cycles; then fetch_err=1, pc and instr unchanged, no fetch_done. A next fetch_start clears fetch_err. With ready in the 16th cycle instead, the fetch succeeds with fetch_err=0.
5. pc_load: pc_load=1 with pc_load_val=32'h40 and fetch_start in the same cycle -> pc=32'h40 and no mem_req. The next fetch issues mem_addr=32'h40, and pc ends at 32'h44. Then pc_load_val=32'h42 followed by fetch_start -> fetch_err=1 and mem_req stays 0.
6. Reset mid-fetch: rst_n=0 during WAIT -> mem_req=0 and pc=RESET_PC after the edge. A later mem_ready=1 causes no change to instr and no fetch_done. Also check pc=32'hFFFFFFFC fetch -> pc wraps to 0.
